ofmap_collector: RTL and testbench
==================================

OFMAP_COLLECTOR -- requirements
Module: ofmap_collector

Interface
REQ-001 SHALL have parameter COLS, default sys_cols (Config), meaning the number of array columns collected.
REQ-002 SHALL have parameter PW, default P_BITWIDTH (Config), meaning the signed partial-sum width per column.
REQ-003 SHALL have parameter OW, default 8, meaning the signed requantized output width per column.
REQ-004 SHALL have parameter DEPTH, default 4, meaning output FIFO depth in vectors (power of 2, >=2).
REQ-005 SHALL have port clk  input  1  the single clock; every register updates on its rising edge.
REQ-006 SHALL have port rst  input  1  synchronous reset, active-high.
REQ-007 SHALL have port start  input  1  one-cycle pulse that loads the configuration and begins a job.
REQ-008 SHALL have port num_vectors  input  16  number of output vectors in the job, sampled on start.
REQ-009 SHALL have port shift  input  $clog2(PW)  arithmetic right-shift amount, sampled on start.
REQ-010 SHALL have port relu_en  input  1  ReLU enable, sampled on start.
REQ-011 SHALL have port in_valid  input  1  high in the cycle column 0 of of_data carries a valid result.
REQ-012 SHALL have port of_data  input  COLS x PW  skewed array outputs; column j is valid j cycles after column 0.
REQ-013 SHALL have port out_valid  output  1  FIFO head vector is valid.
REQ-014 SHALL have port out_ready  input  1  consumer accepts the head vector when high together with out_valid.
REQ-015 SHALL have port out_data  output  COLS x OW  aligned, requantized vector at the FIFO head.
REQ-016 SHALL have port busy  output  1  high from the cycle after start until done.
REQ-017 SHALL have port done  output  1  one-cycle pulse when the job completes.
REQ-018 SHALL have port overflow  output  1  sticky flag: a vector was dropped because the FIFO was full.

Function
REQ-019 SHALL implement FSM states IDLE, COLLECT, DRAIN; start in IDLE moves to COLLECT, or asserts done next cycle and stays IDLE when num_vectors==0.
REQ-020 SHALL ignore start outside IDLE.
REQ-021 SHALL ignore in_valid in IDLE and DRAIN; a per-column valid delay line carries in_valid so column j is captured j cycles after column 0.
REQ-022 SHALL register the full aligned vector in the cycle column COLS-1 is captured; in_valid may be high on consecutive cycles, giving one vector per cycle.
REQ-023 SHALL compute each element as x>>>shift (floor), then 0 if relu_en and the result is negative, then saturate to [-2^(OW-1), 2^(OW-1)-1].
REQ-024 SHALL write the requantized vector into the FIFO so out_valid rises exactly COLS+1 cycles after the in_valid cycle when the FIFO was empty.
REQ-025 SHALL pop on out_valid&&out_ready; out_data SHALL hold stable while out_valid&&!out_ready.
REQ-026 SHALL allow write and pop in the same cycle when full; the write succeeds and the count is unchanged.
REQ-027 SHALL drop a vector written while full with no simultaneous pop, set overflow, and still count it as captured.
REQ-028 SHALL count captured vectors; COLLECT moves to DRAIN in the cycle the count reaches num_vectors.
REQ-029 SHALL leave DRAIN for IDLE with a done pulse in the cycle after the FIFO and pipeline are both empty.
REQ-030 SHALL clear overflow on an accepted start.
REQ-031 SHALL keep FIFO pointers wrapping modulo DEPTH with separate full/empty tracking; no data lost at wrap.

Reset
REQ-032 SHALL, with rst high at a clock edge, enter IDLE and clear FIFO, delay lines, counters, out_valid, busy, done, overflow; out_data SHALL read 0.
REQ-033 SHALL discard any in-flight job on rst mid-operation and produce no done for it.
REQ-034 SHALL give rst priority over start in the same cycle.

Verification
REQ-035 SHALL verify (COLS=4, PW=32, OW=8): start num_vectors=1, shift=0, relu_en=0; in_valid at t with col j = 10*(j+1) at t+j; out_ready=1 -> out_valid at t+5, out_data={10,20,30,40}, done pulse after pop.
REQ-036 SHALL verify requantization: col values {-300, 300, -5, 1024}, shift=2, relu_en=1 -> {0, 75, 0, 127}; same with relu_en=0 -> {-75, 75, -2, 127}.
REQ-037 SHALL verify back-pressure: num_vectors=6, in_valid 6 consecutive cycles, out_ready=0 -> 4 vectors held, overflow=1, 2 dropped; release out_ready -> 4 vectors in order, then done.
REQ-038 SHALL verify wrap/simultaneity: num_vectors=20, continuous in_valid, out_ready=1 -> 20 vectors in order, overflow=0, done once.
REQ-039 SHALL verify boundaries: start num_vectors=0 -> done the next cycle, busy never high; rst asserted mid-job -> all outputs 0, no done, next job correct.

Source files
------------

// File: rtl/ofmap_collector_if.sv
// Stream bundle between the systolic array outputs, the collector and the consumer.
// Latency: none, wires only.
// Backpressure: out_ready from the consumer; the input side has no ready and cannot be stalled.
interface ofmap_collector_if #(
  parameter int COLS = 4,
  parameter int PW   = 32,
  parameter int OW   = 8
);
  logic                     in_valid;
  logic [COLS-1:0][PW-1:0]  of_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [COLS-1:0][OW-1:0]  out_data;

  modport master (
    output in_valid, of_data, out_ready,
    input  out_valid, out_data
  );

  modport slave (
    input  in_valid, of_data, out_ready,
    output out_valid, out_data
  );
endinterface

// File: rtl/ofmap_collector.sv
// De-skews array column outputs, requantizes each vector and queues it in an output FIFO.
// Latency: out_valid rises COLS+1 cycles after the column-0 in_valid cycle when the FIFO is empty.
// Backpressure: FIFO holds DEPTH vectors; a vector arriving while full with no pop is dropped (sticky overflow).
module ofmap_collector #(
  parameter int COLS  = 4,
  parameter int PW    = 32,
  parameter int OW    = 8,
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [15:0]           num_vectors,
  input  logic [$clog2(PW)-1:0] shift,
  input  logic                  relu_en,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  ofmap_collector_if.slave      bus
);

  localparam int SW = $clog2(PW);
  localparam int AW = $clog2(DEPTH);
  localparam logic signed [PW-1:0] MAXV = {{(PW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [PW-1:0] MINV = {{(PW-OW+1){1'b1}}, {(OW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_t;

  state_t                  state_q, state_d;
  logic [15:0]             num_q;
  logic [SW-1:0]           shift_q;
  logic                    relu_q;
  logic [15:0]             cap_cnt_q;
  logic                    done_q, done_d;
  logic                    overflow_q;
  logic [COLS-2:0]         vld_q;
  logic [COLS-1:0]         col_vld;
  logic signed [PW-1:0]    aligned [COLS];
  logic                    rq_vld_q;
  logic [COLS-1:0][OW-1:0] rq_q;
  logic [COLS-1:0][OW-1:0] mem_q [DEPTH];
  logic [AW-1:0]           wr_q, rd_q;
  logic [AW:0]             cnt_q, cnt_d;
  logic                    start_acc, in_acc, pop, full, wr_en, drop, drained;

  // Floor shift, optional ReLU, then clamp into the signed OW-bit range.
  function automatic logic [OW-1:0] requant(input logic signed [PW-1:0] x,
                                            input logic [SW-1:0] sh,
                                            input logic relu);
    logic signed [PW-1:0] y;
    logic [OW-1:0]        r;
    y = x >>> sh;
    if (relu && (y < 0)) y = '0;
    if (y > MAXV)      r = MAXV[OW-1:0];
    else if (y < MINV) r = MINV[OW-1:0];
    else               r = y[OW-1:0];
    return r;
  endfunction

  assign start_acc = (state_q == IDLE) && start;
  assign in_acc    = (state_q == COLLECT) && bus.in_valid;
  // col_vld[j] marks the cycle column j of some vector sits on of_data.
  assign col_vld   = {vld_q, in_acc};

  assign pop       = bus.out_valid && bus.out_ready;
  assign full      = (cnt_q == (AW+1)'(DEPTH));
  assign wr_en     = rq_vld_q && (!full || pop);
  assign drop      = rq_vld_q && full && !pop;
  assign drained   = (vld_q == '0) && !rq_vld_q && (cnt_q == '0);

  assign bus.out_valid = (cnt_q != '0);
  assign bus.out_data  = bus.out_valid ? mem_q[rd_q] : '0;
  assign done          = done_q;
  assign overflow      = overflow_q;

  // Column j needs COLS-1-j extra cycles so every column lines up with the last one.
  for (genvar j = 0; j < COLS; j++) begin : g_dsk
    if (j == COLS-1) begin : g_last
      assign aligned[j] = bus.of_data[j];
    end else begin : g_chain
      localparam int L = COLS-1-j;
      logic signed [PW-1:0] chain_q [L];
      // Per-column data delay line.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int s = 0; s < L; s++) chain_q[s] <= '0;
        end else begin
          chain_q[0] <= bus.of_data[j];
          for (int s = 1; s < L; s++) chain_q[s] <= chain_q[s-1];
        end
      end
      assign aligned[j] = chain_q[L-1];
    end
  end

  // Valid delay line plus the registered, requantized aligned vector.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q    <= '0;
      rq_vld_q <= 1'b0;
      rq_q     <= '0;
    end else begin
      vld_q    <= col_vld[COLS-2:0];
      rq_vld_q <= col_vld[COLS-1];
      if (col_vld[COLS-1]) begin
        for (int j = 0; j < COLS; j++) rq_q[j] <= requant(aligned[j], shift_q, relu_q);
      end
    end
  end

  // FIFO occupancy: simultaneous write and pop leaves the count unchanged.
  always_comb begin
    cnt_d = cnt_q;
    if (wr_en && !pop)      cnt_d = cnt_q + (AW+1)'(1);
    else if (!wr_en && pop) cnt_d = cnt_q - (AW+1)'(1);
  end

  // FIFO storage and wrapping pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (wr_en) begin
        mem_q[wr_q] <= rq_q;
        wr_q        <= wr_q + AW'(1);
      end
      if (pop) rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_d;
    end
  end

  // Job configuration, capture count and the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      num_q      <= '0;
      shift_q    <= '0;
      relu_q     <= 1'b0;
      cap_cnt_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (start_acc) begin
        num_q      <= num_vectors;
        shift_q    <= shift;
        relu_q     <= relu_en;
        cap_cnt_q  <= '0;
        overflow_q <= 1'b0;
      end else begin
        if (col_vld[COLS-1]) cap_cnt_q <= cap_cnt_q + 16'd1;
        if (drop)            overflow_q <= 1'b1;
      end
    end
  end

  // FSM state register and registered done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  // FSM next state; dropped vectors still count toward the job length.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start && (num_vectors != 16'd0)) state_d = COLLECT;
      COLLECT: if (col_vld[COLS-1] && ((cap_cnt_q + 16'd1) == num_q)) state_d = DRAIN;
      DRAIN:   if (drained) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: busy follows the state, done fires for empty jobs or a fully drained job.
  always_comb begin
    busy   = (state_q != IDLE);
    done_d = 1'b0;
    if ((state_q == IDLE) && start && (num_vectors == 16'd0)) done_d = 1'b1;
    if ((state_q == DRAIN) && drained)                         done_d = 1'b1;
  end

endmodule

// File: tb/tb_ofmap_collector.sv
// Directed and randomized jobs against a queue-based reference of the collector.
// Latency: checks first out_valid at COLS+1 cycles after in_valid.
// Backpressure: exercises held out_ready, drops and release.
module tb_ofmap_collector;
  localparam int COLS  = 4;
  localparam int PW    = 32;
  localparam int OW    = 8;
  localparam int DEPTH = 4;
  localparam int SW    = $clog2(PW);
  localparam int VW    = COLS*OW;

  logic          clk;
  logic          rst;
  logic          start;
  logic [15:0]   num_vectors;
  logic [SW-1:0] shift;
  logic          relu_en;
  logic          busy, done, overflow;

  ofmap_collector_if #(.COLS(COLS), .PW(PW), .OW(OW)) bus ();

  ofmap_collector #(.COLS(COLS), .PW(PW), .OW(OW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .num_vectors(num_vectors),
    .shift(shift), .relu_en(relu_en), .busy(busy), .done(done),
    .overflow(overflow), .bus(bus)
  );

  int vectors_applied = 0;
  int miscompares     = 0;
  int cyc             = 0;
  int t0              = 0;
  int vals [32][COLS];

  logic [VW-1:0] expq[$];
  int  got, dones, first_ov;
  bit  busy_seen;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors_applied++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference requantization: floor division by 2^sh, ReLU, clamp.
  function automatic logic [OW-1:0] ref_rq(input int x, input int sh, input bit relu);
    longint d, q, lo, hi;
    d  = longint'(1) << sh;
    q  = longint'(x) / d;
    if ((longint'(x) % d != 0) && (x < 0)) q = q - 1;
    if (relu && (q < 0)) q = 0;
    hi = (longint'(1) << (OW-1)) - 1;
    lo = -(longint'(1) << (OW-1));
    if (q > hi) q = hi;
    if (q < lo) q = lo;
    return q[OW-1:0];
  endfunction

  function automatic logic [VW-1:0] ref_vec(input int k, input int sh, input bit relu);
    logic [VW-1:0] v;
    v = '0;
    for (int j = 0; j < COLS; j++) v[j*OW +: OW] = ref_rq(vals[k][j], sh, relu);
    return v;
  endfunction

  task fill_random(input int n);
    for (int k = 0; k < n; k++)
      for (int j = 0; j < COLS; j++)
        case ($urandom_range(0, 2))
          0:       vals[k][j] = int'($urandom_range(0, 1000)) - 500;
          1:       vals[k][j] = int'($urandom);
          default: vals[k][j] = int'($urandom_range(0, 100000)) - 50000;
        endcase
  endtask

  // Skewed drive: column j of vector k appears c = k + j cycles into the burst.
  task drive_vectors(input int n);
    t0 = cyc;
    for (int c = 0; c < n + COLS - 1; c++) begin
      bus.in_valid = (c < n);
      for (int j = 0; j < COLS; j++) begin
        if ((c - j >= 0) && (c - j < n)) bus.of_data[j] = vals[c-j][j];
        else                             bus.of_data[j] = $urandom;
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
  endtask

  task run_job(input int n, input int sh, input bit relu, input bit hold);
    expq = {};
    for (int k = 0; k < n; k++)
      if (!hold || k < DEPTH) expq.push_back(ref_vec(k, sh, relu));
    got = 0; dones = 0; first_ov = -1; busy_seen = 0;
    @(posedge clk); #1;
    start = 1'b1; num_vectors = 16'(n); shift = SW'(sh); relu_en = relu;
    bus.out_ready = !hold;
    @(posedge clk); #1;
    start = 1'b0; num_vectors = 16'($urandom); shift = SW'($urandom); relu_en = 1'($urandom);
    fork
      drive_vectors(n);
      begin
        for (int c = 0; c < 400; c++) begin
          @(negedge clk);
          if (bus.out_valid && first_ov < 0) first_ov = cyc;
          if (hold && n > 0 && c == n + COLS + 4) begin
            check("held_valid", bus.out_valid, 1);
            check("held_head", bus.out_data, expq[0]);
            check("held_overflow", overflow, (n > DEPTH));
            bus.out_ready = 1'b1;
          end
          if (busy) busy_seen = 1;
          if (bus.out_valid && bus.out_ready) begin
            if (got < expq.size()) check("data", bus.out_data, expq[got]);
            got++;
          end
          if (done) dones++;
          if (dones > 0) break;
        end
        check("busy_at_done", busy, 0);
        repeat (4) begin
          @(negedge clk);
          if (done) dones++;
        end
      end
    join
    check("done_count", dones, 1);
    check("pop_count", got, expq.size());
    check("overflow_end", overflow, (hold && n > DEPTH));
    check("busy_seen", busy_seen, (n > 0));
    check("idle_out_valid", bus.out_valid, 0);
    if (!hold && n > 0) check("latency", first_ov - t0, COLS + 1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; num_vectors = '0; shift = '0; relu_en = 1'b0;
    bus.in_valid = 1'b0; bus.of_data = '0; bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_overflow", overflow, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single vector, identity requantization.
    vals[0] = '{10, 20, 30, 40};
    run_job(1, 0, 0, 0);

    // Requantization with and without ReLU.
    vals[0] = '{-300, 300, -5, 1024};
    run_job(1, 2, 1, 0);
    run_job(1, 2, 0, 0);

    // Empty job.
    run_job(0, 0, 0, 0);

    // Back-pressure: 6 vectors into a 4-deep FIFO.
    fill_random(6);
    run_job(6, $urandom_range(0, 10), 1'($urandom), 1);

    // Pointer wrap with continuous flow.
    fill_random(20);
    run_job(20, $urandom_range(0, 12), 1'($urandom), 0);

    // Reset mid-job with start asserted in the same cycle.
    fill_random(5);
    @(posedge clk); #1;
    start = 1'b1; num_vectors = 16'd5; shift = '0; relu_en = 1'b0; bus.out_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    drive_vectors(5);
    @(negedge clk);
    check("pre_rst_valid", bus.out_valid, 1);
    @(posedge clk); #1;
    rst = 1'b1; start = 1'b1; num_vectors = 16'd3;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_out_data", bus.out_data, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_overflow", overflow, 0);
    dones = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("midrst_no_done", dones, 0);

    fill_random(5);
    run_job(5, $urandom_range(0, 8), 1'($urandom), 0);

    // Random jobs, some under held back-pressure.
    for (int i = 0; i < 6; i++) begin
      int n;
      n = $urandom_range(1, 12);
      fill_random(n);
      run_job(n, $urandom_range(0, 16), 1'($urandom), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end
endmodule
